key_debouncer: RTL and testbench

//   Conditions the raw, active-low KEY push-buttons before they reach the

---
 rtl/key_debouncer.sv | 86 ++++++++
 tb/tb_key_debouncer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_debouncer.sv
// Key conditioning: 2-flop sync, per-channel debounce counter, registered level and press/release pulses.
// Optional build macro KEY_LOCKOUT_EN: while any key is held, idle channels cannot accept a new press.
module key_debouncer_lane #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic key,
  input  logic lock,
  output logic level_n,
  output logic level_nxt,
  output logic press,
  output logic rls
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1, s2;
  logic [CW-1:0] cnt;
  logic          diff, done;

  // Counter only advances while the synced input disagrees with the accepted level.
  assign diff      = (s2 != level_n) && !lock;
  assign done      = diff && (cnt == LAST);
  assign level_nxt = done ? s2 : level_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1      <= 1'b1;
      s2      <= 1'b1;
      cnt     <= '0;
      level_n <= 1'b1;
      press   <= 1'b0;
      rls     <= 1'b0;
    end else begin
      s1      <= key;
      s2      <= s1;
      level_n <= level_nxt;
      press   <= done & ~s2;
      rls     <= done & s2;
      if (!diff || done) cnt <= '0;
      else               cnt <= cnt + CW'(1);
    end
  end
endmodule

module key_debouncer #(
  parameter int WIDTH           = 3,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic [WIDTH-1:0] KEY,
  output logic [WIDTH-1:0] key_level_n,
  output logic [WIDTH-1:0] key_press,
  output logic [WIDTH-1:0] key_release,
  output logic             any_held
);
  logic [WIDTH-1:0] level_nxt;
  logic [WIDTH-1:0] lock;

`ifdef KEY_LOCKOUT_EN
  // Only released channels are locked, so releases always go through.
  assign lock = {WIDTH{any_held}} & key_level_n;
`else
  assign lock = '0;
`endif

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    key_debouncer_lane #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lane (
      .clk       (CLOCK_50),
      .reset     (reset),
      .key       (KEY[i]),
      .lock      (lock[i]),
      .level_n   (key_level_n[i]),
      .level_nxt (level_nxt[i]),
      .press     (key_press[i]),
      .rls       (key_release[i])
    );
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) any_held <= 1'b0;
    else       any_held <= ~&level_nxt;
  end
endmodule

// File: tb/tb_key_debouncer.sv
// Scoreboard bench for key_debouncer (WIDTH=3, DEBOUNCE_CYCLES=4); honours KEY_LOCKOUT_EN if defined.
module tb_key_debouncer;
  localparam int W  = 3;
  localparam int DC = 4;
  localparam int LAT = DC + 2;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] KEY = '0;
  logic [W-1:0] key_level_n, key_press, key_release;
  logic         any_held;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    int           cyc;
    logic [W-1:0] press;
    logic [W-1:0] rls;
    logic [W-1:0] lvl;
    logic         held;
  } ev_t;
  ev_t sb[$];

  key_debouncer #(.WIDTH(W), .DEBOUNCE_CYCLES(DC)) dut (
    .CLOCK_50    (clk),
    .reset       (reset),
    .KEY         (KEY),
    .key_level_n (key_level_n),
    .key_press   (key_press),
    .key_release (key_release),
    .any_held    (any_held)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Every pulse must match the next expected event, including the edge it lands on.
  always @(negedge clk) begin
    if ((key_press | key_release) != '0) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse cyc=%0d press=%b rel=%b lvl=%b", cyc, key_press, key_release, key_level_n);
      end else begin
        ev_t e;
        e = sb.pop_front();
        if (e.cyc !== cyc || e.press !== key_press || e.rls !== key_release ||
            e.lvl !== key_level_n || e.held !== any_held) begin
          errors++;
          $display("FAIL pulse_event got cyc=%0d press=%b rel=%b lvl=%b held=%b want cyc=%0d press=%b rel=%b lvl=%b held=%b",
                   cyc, key_press, key_release, key_level_n, any_held,
                   e.cyc, e.press, e.rls, e.lvl, e.held);
        end
      end
    end
  end

  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic push(input int c, input logic [W-1:0] p, input logic [W-1:0] r,
                      input logic [W-1:0] l, input logic h);
    sb.push_back('{cyc: c, press: p, rls: r, lvl: l, held: h});
  endtask

  task automatic test_reset;
    int r;
    KEY = 3'b000;
    reset = 1'b1;
    tick(3);
    checks++;
    if (key_level_n !== 3'b111 || key_press !== 3'b000 || key_release !== 3'b000 || any_held !== 1'b0) begin
      errors++;
      $display("FAIL reset_state lvl=%b press=%b rel=%b held=%b want 111/000/000/0",
               key_level_n, key_press, key_release, any_held);
    end
    reset = 1'b0;
    KEY = 3'b110;
    r = cyc;
    push(r + LAT, 3'b001, 3'b000, 3'b110, 1'b1);
    tick(LAT - 1);
    checks++;
    if (key_level_n !== 3'b111) begin
      errors++;
      $display("FAIL reset_latency_early lvl=%b want 111", key_level_n);
    end
    tick(2);
    checks++;
    if (key_level_n !== 3'b110 || key_press !== 3'b000 || any_held !== 1'b1) begin
      errors++;
      $display("FAIL reset_after_press lvl=%b press=%b held=%b want 110/000/1", key_level_n, key_press, any_held);
    end
    r = cyc;
    KEY = 3'b111;
    push(r + LAT, 3'b000, 3'b001, 3'b111, 1'b0);
    tick(LAT + 2);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL reset_events_missing left=%0d want 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_glitch;
    int n;
    KEY = 3'b101; tick(1);
    KEY = 3'b111; tick(1);
    KEY = 3'b101; tick(1);
    KEY = 3'b111; tick(12);
    checks++;
    if (key_level_n !== 3'b111) begin
      errors++;
      $display("FAIL glitch_short lvl=%b want 111", key_level_n);
    end
    KEY = 3'b101; tick(DC - 1);
    KEY = 3'b111; tick(12);
    checks++;
    if (key_level_n !== 3'b111) begin
      errors++;
      $display("FAIL glitch_dc_minus_1 lvl=%b want 111", key_level_n);
    end
    n = cyc;
    KEY = 3'b101;
    push(n + LAT, 3'b010, 3'b000, 3'b101, 1'b1);
    tick(DC);
    KEY = 3'b111;
    push(n + DC + LAT, 3'b000, 3'b010, 3'b111, 1'b0);
    tick(12);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL glitch_exact_dc_missing left=%0d want 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_press_release;
    int n;
    n = cyc;
    KEY = 3'b011;
    push(n + LAT, 3'b100, 3'b000, 3'b011, 1'b1);
    tick(20);
    checks++;
    if (key_level_n !== 3'b011 || any_held !== 1'b1) begin
      errors++;
      $display("FAIL press_hold lvl=%b held=%b want 011/1", key_level_n, any_held);
    end
    n = cyc;
    KEY = 3'b111;
    push(n + LAT, 3'b000, 3'b100, 3'b111, 1'b0);
    tick(LAT + 3);
    checks++;
    if (sb.size() != 0 || key_level_n !== 3'b111) begin
      errors++;
      $display("FAIL press_release_missing left=%0d lvl=%b want 0/111", sb.size(), key_level_n);
      sb.delete();
    end
  endtask

  task automatic test_simultaneous;
    int n;
    n = cyc;
    KEY = 3'b100;
    push(n + LAT, 3'b011, 3'b000, 3'b100, 1'b1);
    tick(10);
    n = cyc;
    KEY = 3'b101;
    push(n + LAT, 3'b000, 3'b001, 3'b101, 1'b1);
    tick(10);
    checks++;
    if (any_held !== 1'b1 || key_level_n !== 3'b101) begin
      errors++;
      $display("FAIL simul_partial held=%b lvl=%b want 1/101", any_held, key_level_n);
    end
    n = cyc;
    KEY = 3'b111;
    push(n + LAT, 3'b000, 3'b010, 3'b111, 1'b0);
    tick(10);
    checks++;
    if (sb.size() != 0 || any_held !== 1'b0) begin
      errors++;
      $display("FAIL simul_missing left=%0d held=%b want 0/0", sb.size(), any_held);
      sb.delete();
    end
  endtask

  task automatic test_reset_mid;
    int n;
    n = cyc;
    KEY = 3'b101;
    push(n + LAT, 3'b010, 3'b000, 3'b101, 1'b1);
    tick(10);
    reset = 1'b1;
    tick(1);
    checks++;
    if (key_level_n !== 3'b111 || any_held !== 1'b0 || key_press !== 3'b000) begin
      errors++;
      $display("FAIL reset_mid_state lvl=%b held=%b press=%b want 111/0/000", key_level_n, any_held, key_press);
    end
    reset = 1'b0;
    n = cyc;
    push(n + LAT, 3'b010, 3'b000, 3'b101, 1'b1);
    tick(10);
    n = cyc;
    KEY = 3'b111;
    push(n + LAT, 3'b000, 3'b010, 3'b111, 1'b0);
    tick(10);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL reset_mid_missing left=%0d want 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_lockout;
    int n;
    n = cyc;
    KEY = 3'b110;
    push(n + LAT, 3'b001, 3'b000, 3'b110, 1'b1);
    tick(10);
    n = cyc;
    KEY = 3'b010;
`ifdef KEY_LOCKOUT_EN
    tick(12);
    checks++;
    if (key_level_n !== 3'b110) begin
      errors++;
      $display("FAIL lockout_blocked lvl=%b want 110", key_level_n);
    end
    n = cyc;
    KEY = 3'b111;
    push(n + LAT, 3'b000, 3'b001, 3'b111, 1'b0);
    tick(10);
    n = cyc;
    KEY = 3'b011;
    push(n + LAT, 3'b100, 3'b000, 3'b011, 1'b1);
    tick(10);
    n = cyc;
    KEY = 3'b111;
    push(n + LAT, 3'b000, 3'b100, 3'b111, 1'b0);
`else
    push(n + LAT, 3'b100, 3'b000, 3'b010, 1'b1);
    tick(12);
    checks++;
    if (key_level_n !== 3'b010) begin
      errors++;
      $display("FAIL independent_second lvl=%b want 010", key_level_n);
    end
    n = cyc;
    KEY = 3'b111;
    push(n + LAT, 3'b000, 3'b101, 3'b111, 1'b0);
`endif
    tick(10);
    checks++;
    if (sb.size() != 0 || key_level_n !== 3'b111) begin
      errors++;
      $display("FAIL lockout_missing left=%0d lvl=%b want 0/111", sb.size(), key_level_n);
      sb.delete();
    end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_press_release();
    test_simultaneous();
    test_reset_mid();
    test_lockout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
